// File: rtl/alu_decoder.sv
// alu_decoder: turns the main-decoder ALUOp class plus funct3, funct7 bit 5 and
// opcode bit 5 into the 3-bit ALUControl word for the single-cycle RISC-V ALU.
// The decoded word is registered: it updates one rising edge after the inputs
// are presented with en = 1, and holds its value while en = 0.
// Optional feature macro: ALU_DECODER_ILLEGAL_FLAG_EN adds a registered
// 'illegal' output that flags the reserved ALUOp and R-type encodings that set
// bit 30 where that bit has no meaning.

module alu_decoder #(
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic [6:0]        opcode_5,
`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
  output logic              illegal,
`endif
  output logic [CTRL_W-1:0] ALUControl
);

  // ALU operation codes
  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'b101;
  localparam logic [CTRL_W-1:0] ALU_SLL = 3'b110;
  localparam logic [CTRL_W-1:0] ALU_SRA = 3'b111;

  // ALUOp classes from the main decoder
  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_ALU    = 2'b10;

  logic [CTRL_W-1:0] w_ctrl;
  logic [CTRL_W-1:0] r_ctrl;
  logic              w_rtype;
  logic              w_unused_opcode;

  // Only opcode bit 5 distinguishes R-type from I-type; the rest is unused
  assign w_rtype         = opcode_5[5];
  assign w_unused_opcode = ^{opcode_5[6], opcode_5[4:0]};

  // Decode ALUOp first so funct3/funct7_5/opcode are never read (and X never
  // leaks through) for the load/store and branch classes
  always_comb begin
    w_ctrl = ALU_ADD;
    case (ALUOp)
      OP_MEM:    w_ctrl = ALU_ADD;
      OP_BRANCH: w_ctrl = ALU_SUB;
      OP_ALU: begin
        case (funct3)
          3'b000:  w_ctrl = (w_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  w_ctrl = ALU_SLL;
          3'b010:  w_ctrl = ALU_SLT;
          3'b011:  w_ctrl = ALU_SLT;
          3'b100:  w_ctrl = ALU_XOR;
          3'b101:  w_ctrl = ALU_SRA;
          3'b110:  w_ctrl = ALU_OR;
          3'b111:  w_ctrl = ALU_AND;
          default: w_ctrl = ALU_ADD;
        endcase
      end
      default:   w_ctrl = ALU_ADD;
    endcase
  end

  // Output register: synchronous reset to add, otherwise load when enabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl <= ALU_ADD;
    end else if (en) begin
      r_ctrl <= w_ctrl;
    end
  end

  assign ALUControl = r_ctrl;

`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
  logic w_illegal;
  logic r_illegal;

  // Flag reserved ALUOp, and R-type with bit 30 set where only add/sub and
  // the shift-right pair give bit 30 a meaning
  always_comb begin
    w_illegal = 1'b0;
    case (ALUOp)
      OP_MEM:    w_illegal = 1'b0;
      OP_BRANCH: w_illegal = 1'b0;
      OP_ALU:    w_illegal = w_rtype && funct7_5 &&
                             (funct3 != 3'b000) && (funct3 != 3'b101);
      default:   w_illegal = 1'b1;
    endcase
  end

  // Illegal flag register shares the reset and hold behaviour of ALUControl
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (en) begin
      r_illegal <= w_illegal;
    end
  end

  assign illegal = r_illegal;
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// tb_alu_decoder: directed vectors for alu_decoder with hand-computed expected
// values. The driver pushes the value ALUControl must show after each rising
// edge into a scoreboard queue; an independent monitor pops and compares on
// the following falling edge.

module tb_alu_decoder;

  typedef struct {
    string      name;
    logic [2:0] ctrl;
    logic       ill;
  } expect_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [6:0] opcode_5;
  logic [2:0] ALUControl;
`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
  logic       illegal;
`endif

  expect_t scoreboard[$];
  expect_t popped;
  int      testsRun    = 0;
  int      testsFailed = 0;

  alu_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ALUOp      (ALUOp),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .opcode_5   (opcode_5),
`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
    .illegal    (illegal),
`endif
    .ALUControl (ALUControl)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then record what must be visible after the edge
  task automatic applyStimulus(input string name, input logic rstN, input logic enable,
                               input logic [1:0] aluOp, input logic [2:0] f3,
                               input logic f7, input logic [6:0] op,
                               input logic [2:0] expCtrl, input logic expIll);
    expect_t e;
    @(negedge clk);
    #1;
    rst_n    = rstN;
    en       = enable;
    ALUOp    = aluOp;
    funct3   = f3;
    funct7_5 = f7;
    opcode_5 = op;
    @(posedge clk);
    e.name = name;
    e.ctrl = expCtrl;
    e.ill  = expIll;
    scoreboard.push_back(e);
  endtask

  // Compare the DUT outputs against one scoreboard entry
  task automatic checkOutput(input expect_t e);
    testsRun++;
    if (ALUControl !== e.ctrl) begin
      testsFailed++;
      $display("[TB] FAIL %s: ALUControl got %b expected %b", e.name, ALUControl, e.ctrl);
    end
`ifdef ALU_DECODER_ILLEGAL_FLAG_EN
    testsRun++;
    if (illegal !== e.ill) begin
      testsFailed++;
      $display("[TB] FAIL %s: illegal got %b expected %b", e.name, illegal, e.ill);
    end
`endif
  endtask

  // Monitor: one scoreboard entry is due at each falling edge after a push
  always @(negedge clk) begin
    if (scoreboard.size() > 0) begin
      popped = scoreboard.pop_front();
      checkOutput(popped);
    end
  end

  // Directed stimulus
  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    ALUOp    = 2'b01;
    funct3   = 3'b000;
    funct7_5 = 1'b0;
    opcode_5 = 7'b0000000;

    // Reset dominates an ALUOp of branch
    applyStimulus("reset0",        1'b0, 1'b1, 2'b01, 3'b000, 1'b0, 7'b0000000, 3'b000, 1'b0);
    applyStimulus("reset1",        1'b0, 1'b1, 2'b01, 3'b000, 1'b0, 7'b0000000, 3'b000, 1'b0);
    applyStimulus("release_sub",   1'b1, 1'b1, 2'b01, 3'b000, 1'b0, 7'b0000000, 3'b001, 1'b0);

    // Don't-care inputs for memory and branch classes
    applyStimulus("mem_x",         1'b1, 1'b1, 2'b00, 3'bxxx, 1'bx, 7'bxxxxxxx, 3'b000, 1'b0);
    applyStimulus("branch_x",      1'b1, 1'b1, 2'b01, 3'bxxx, 1'bx, 7'bxxxxxxx, 3'b001, 1'b0);

    // funct3 = 000: add/sub selection
    applyStimulus("add_f7_0",      1'b1, 1'b1, 2'b10, 3'b000, 1'b0, 7'b0000000, 3'b000, 1'b0);
    applyStimulus("sub_rtype",     1'b1, 1'b1, 2'b10, 3'b000, 1'b1, 7'b0110011, 3'b001, 1'b0);
    applyStimulus("addi_bit30",    1'b1, 1'b1, 2'b10, 3'b000, 1'b1, 7'b0010011, 3'b000, 1'b0);

    // Remaining funct3 codes
    applyStimulus("slt",           1'b1, 1'b1, 2'b10, 3'b010, 1'b0, 7'b0110011, 3'b101, 1'b0);
    applyStimulus("or",            1'b1, 1'b1, 2'b10, 3'b110, 1'b0, 7'b0110011, 3'b011, 1'b0);
    applyStimulus("and",           1'b1, 1'b1, 2'b10, 3'b111, 1'b0, 7'b0110011, 3'b010, 1'b0);
    applyStimulus("sra",           1'b1, 1'b1, 2'b10, 3'b101, 1'b1, 7'b0110011, 3'b111, 1'b0);
    applyStimulus("sll",           1'b1, 1'b1, 2'b10, 3'b001, 1'b0, 7'b0010011, 3'b110, 1'b0);
    applyStimulus("xor",           1'b1, 1'b1, 2'b10, 3'b100, 1'b0, 7'b0110011, 3'b100, 1'b0);
    applyStimulus("sltu",          1'b1, 1'b1, 2'b10, 3'b011, 1'b0, 7'b0110011, 3'b101, 1'b0);
    applyStimulus("srli",          1'b1, 1'b1, 2'b10, 3'b101, 1'b0, 7'b0010011, 3'b111, 1'b0);
    applyStimulus("slti_bit30",    1'b1, 1'b1, 2'b10, 3'b010, 1'b1, 7'b0010011, 3'b101, 1'b0);

    // Hold with en = 0, then update on re-enable
    applyStimulus("and_pre_hold",  1'b1, 1'b1, 2'b10, 3'b111, 1'b0, 7'b0110011, 3'b010, 1'b0);
    applyStimulus("hold0",         1'b1, 1'b0, 2'b01, 3'b111, 1'b0, 7'b0110011, 3'b010, 1'b0);
    applyStimulus("hold1",         1'b1, 1'b0, 2'b01, 3'b111, 1'b0, 7'b0110011, 3'b010, 1'b0);
    applyStimulus("hold_release",  1'b1, 1'b1, 2'b01, 3'b111, 1'b0, 7'b0110011, 3'b001, 1'b0);

    // Reserved class and R-type with bit 30 on a non add/shift funct3
    applyStimulus("reserved",      1'b1, 1'b1, 2'b11, 3'b010, 1'b0, 7'b0110011, 3'b000, 1'b1);
    applyStimulus("and_bit30",     1'b1, 1'b1, 2'b10, 3'b111, 1'b1, 7'b0110011, 3'b010, 1'b1);

    // Mid-stream reset overrides a held flag and a pending decode, even with en = 0
    applyStimulus("reserved2",     1'b1, 1'b1, 2'b11, 3'b000, 1'b0, 7'b0000000, 3'b000, 1'b1);
    applyStimulus("hold_flag",     1'b1, 1'b0, 2'b10, 3'b110, 1'b0, 7'b0110011, 3'b000, 1'b1);
    applyStimulus("reset_no_en",   1'b0, 1'b0, 2'b10, 3'b110, 1'b0, 7'b0110011, 3'b000, 1'b0);
    applyStimulus("or_post_reset", 1'b1, 1'b1, 2'b10, 3'b110, 1'b0, 7'b0110011, 3'b011, 1'b0);
    applyStimulus("reset_midrun",  1'b0, 1'b1, 2'b01, 3'b000, 1'b0, 7'b0000000, 3'b000, 1'b0);
    applyStimulus("sub_after",     1'b1, 1'b1, 2'b01, 3'b000, 1'b0, 7'b0000000, 3'b001, 1'b0);

    // Let the monitor drain the queue within a bounded number of cycles
    for (int i = 0; i < 5 && scoreboard.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (scoreboard.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: pending entries got %0d expected 0", scoreboard.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time got 50000 expected completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_decoder.md
Name: alu_decoder

Overview:
- Decodes the main-decoder ALUOp class, funct3, funct7 bit 5 and opcode into a 3-bit ALUControl word for the single-cycle RISC-V datapath ALU.
- Output is registered: one clock of latency, held while the stage is stalled.
- Sits between the main control decoder and the ALU.

Parameters:
- CTRL_W, 3, width of ALUControl; fixed at 3 and not intended to be changed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- en  input  1  update enable; 1 = register new decode, 0 = hold ALUControl.
- ALUOp  input  2  class from main decoder: 00 load/store/addi-address, 01 branch, 10 R/I-type ALU, 11 reserved.
- funct3  input  3  instruction bits [14:12].
- funct7_5  input  1  instruction bit 30.
- opcode_5  input  7  full opcode [6:0]; only bit 5 is used (1 = R-type, 0 = I-type).
- ALUControl  output  3  registered ALU operation code.

Behaviour:
- Reset:
  - rst_n low at a rising edge forces ALUControl = 000 (add) on that edge, regardless of en.
  - Reset asserted mid-stream overrides any pending decode.
- Latency:
  - Decode is combinational.
  - ALUControl updates on the rising edge after inputs are presented with en = 1 and rst_n = 1.
- Hold: en = 0 keeps ALUControl unchanged.
- Encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 sra.
- ALUOp = 00 -> 000 (add); funct3/funct7_5/opcode_5 are don't-care and may be X/unknown without affecting the result.
- ALUOp = 01 -> 001 (sub); other inputs are don't-care, same X-tolerance.
- ALUOp = 10, decoded by funct3:
  - 000: 001 (sub) only if opcode_5[5] = 1 AND funct7_5 = 1; otherwise 000 (add). I-type addi with bit 30 set is still add.
  - 001: 110 (sll).
  - 010: 101 (slt).
  - 011: 101 (sltu shares slt code; unsigned compare is not distinguished in this encoding).
  - 100: 100 (xor).
  - 101: 111 (sra); funct7_5 is ignored, so srl/srli also decode to 111.
  - 110: 011 (or).
  - 111: 010 (and).
- ALUOp = 11 (reserved) -> 000 (add).
- X-safety: a select with ALUOp = 00/01 must never propagate X to ALUControl. Use a case on ALUOp first, with funct3 decoded only in the 10 branch.
- No other state; no handshake beyond en.

Optional Feature:
- Macro ALU_DECODER_ILLEGAL_FLAG_EN.
- Defined:
  - Adds output port illegal (1 bit), registered with the same timing, reset and en-hold rules as ALUControl; reset value 0.
  - illegal = 1 when ALUOp = 11.
  - illegal = 1 when ALUOp = 10, opcode_5[5] = 1 (R-type) and funct7_5 = 1 with funct3 not in {000, 101}.
  - ALUControl encoding is unchanged in all cases.
- Undefined: port absent; behaviour identical otherwise.

Test Plan:
- rst_n = 0 for 2 cycles with ALUOp = 01 -> ALUControl = 000. Release rst_n with en = 1 -> ALUControl = 001 one edge later.
- ALUOp = 00, funct3/funct7_5/opcode_5 = X -> 000. Then ALUOp = 01, same X inputs -> 001. No X on output.
- ALUOp = 10, funct3 = 000:
  - funct7_5 = 0, opcode_5 = 0000000 -> 000.
  - funct7_5 = 1, opcode_5 = 0110011 -> 001.
  - funct7_5 = 1, opcode_5 = 0010011 -> 000.
- ALUOp = 10, funct3 = 010 -> 101; 110 -> 011; 111 -> 010; 101 -> 111; 001 -> 110; 100 -> 100.
- Hold: set en = 0, then change ALUOp 10 -> 01 with funct3 = 111 -> ALUControl stays 010 until en = 1, then becomes 001 one edge later.
- With ALU_DECODER_ILLEGAL_FLAG_EN: ALUOp = 11 -> ALUControl = 000, illegal = 1. ALUOp = 10, funct3 = 111, funct7_5 = 1, opcode_5 = 0110011 -> ALUControl = 010, illegal = 1.
